// File: rtl/ex_div_pkg.sv
// Shared constants and arithmetic helpers for the EX-stage divider.
package ex_div_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  // FSM state encodings
  localparam logic [1:0] DIV_FREE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  // ready_o levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // start_i levels as driven by EX
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Last value of the iteration counter; the step taken there is the 32nd.
  localparam logic [5:0] DIV_LAST_STEP = 6'd31;

  // Two's-complement negate when en is set, pass through otherwise.
  function automatic logic [REG_W-1:0] cond_negate(input logic [REG_W-1:0] v,
                                                   input logic en);
    logic [REG_W-1:0] r;
    if (en) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One restoring-division step.
  // pr layout: [64:32] partial remainder (always < divisor, so bit 64 stays 0),
  //            [31:0]  dividend bits still to shift in / quotient bits shifted out.
  // The remainder is shifted left taking the next dividend bit; if the divisor
  // fits, it is subtracted and a 1 enters the quotient, otherwise a 0.
  function automatic logic [64:0] div_step(input logic [64:0] pr,
                                           input logic [REG_W-1:0] d);
    logic [33:0] trial;
    logic [64:0] r;
    trial = pr[64:31] - {2'b00, d};
    if (trial[33]) begin
      r = {pr[63:0], 1'b0};
    end else begin
      r = {trial[32:0], pr[30:0], 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for the EX stage.
// Result is {remainder, quotient}; divide by zero yields an all-zero result.
module ex_div
  import ex_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o
);

  logic [1:0]        state_r;
  logic [5:0]        cnt_r;
  logic [64:0]       pr_r;
  logic [REG_W-1:0]  divisor_r;
  logic              neg_quo_r;
  logic              neg_rem_r;
  logic [DREG_W-1:0] result_r;
  logic              ready_r;

  logic [64:0]       step_s;
  logic [REG_W-1:0]  quo_fix_s;
  logic [REG_W-1:0]  rem_fix_s;
  logic              neg_op1_s;
  logic              neg_op2_s;

  assign neg_op1_s = signed_div_i & opdata1_i[31];
  assign neg_op2_s = signed_div_i & opdata2_i[31];

  // Next partial remainder plus sign fix-up of the value the step produces.
  always_comb begin
    step_s    = div_step(pr_r, divisor_r);
    quo_fix_s = cond_negate(step_s[31:0], neg_quo_r);
    rem_fix_s = cond_negate(step_s[63:32], neg_rem_r);
  end

  // Divider FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= DIV_FREE;
      cnt_r     <= 6'd0;
      pr_r      <= 65'd0;
      divisor_r <= 32'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= 64'd0;
      ready_r   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_r)
        DIV_FREE: begin
          result_r <= 64'd0;
          ready_r  <= DIV_RESULT_NOT_READY;
          if ((start_i == DIV_START) && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_r <= DIV_BYZERO;
            end else begin
              // Iterate on magnitudes; signs are re-applied on the last step.
              state_r   <= DIV_ON;
              cnt_r     <= 6'd0;
              pr_r      <= {33'd0, cond_negate(opdata1_i, neg_op1_s)};
              divisor_r <= cond_negate(opdata2_i, neg_op2_s);
              neg_quo_r <= neg_op1_s ^ neg_op2_s;
              neg_rem_r <= neg_op1_s;
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i) begin
            state_r  <= DIV_FREE;
            result_r <= 64'd0;
            ready_r  <= DIV_RESULT_NOT_READY;
          end else begin
            state_r  <= DIV_END;
            result_r <= 64'd0;
            ready_r  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state_r  <= DIV_FREE;
            cnt_r    <= 6'd0;
            result_r <= 64'd0;
            ready_r  <= DIV_RESULT_NOT_READY;
          end else begin
            pr_r <= step_s;
            if (cnt_r == DIV_LAST_STEP) begin
              // 32nd step: publish the fixed-up result on this same edge.
              state_r  <= DIV_END;
              cnt_r    <= 6'd0;
              result_r <= {rem_fix_s, quo_fix_s};
              ready_r  <= DIV_RESULT_READY;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        DIV_END: begin
          // annul_i is deliberately ignored here: EX releases us via start_i.
          if (start_i == DIV_STOP) begin
            state_r  <= DIV_FREE;
            result_r <= 64'd0;
            ready_r  <= DIV_RESULT_NOT_READY;
          end else begin
            state_r <= DIV_END;
          end
        end
        default: begin
          state_r  <= DIV_FREE;
          cnt_r    <= 6'd0;
          result_r <= 64'd0;
          ready_r  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against an arithmetic reference.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {remainder, quotient} from plain integer division.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb, q, r;
    logic [63:0] res;
    if (b == 32'd0) begin
      res = 64'd0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full handshake: request, latency, hold in END (with a stray annul), release.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input string tag);
    logic [63:0] exp;
    int exp_lat;
    int lat;
    exp     = model(a, b, sgn);
    exp_lat = (b == 32'd0) ? 2 : 33;
    lat     = 0;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    for (int k = 1; k <= 40; k++) begin
      tick();
      // Operands are latched on acceptance; later changes must not matter.
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp);
    for (int i = 0; i < 5; i++) begin
      annul_i = (i == 2);
      tick();
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_result"}, result_o, exp);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check({tag, "_release_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_release_result"}, result_o, 64'd0);
  endtask

  // Start a long divide and let it run n edges past (and including) acceptance.
  task automatic begin_div(input int n);
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000000;
    opdata2_i    = 32'd7;
    for (int k = 0; k < n; k++) begin
      tick();
    end
  endtask

  // Idle for n edges; ready must never rise.
  task automatic idle_quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      seen = seen | ready_o;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    rst          = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, "u100_7");
    check("u100_7_model", model(32'd100, 32'd7, 1'b0), {32'h00000002, 32'h0000000E});
    do_div(32'hFFFFFFF9, 32'h00000002, 1'b1, "s_m7_2");
    do_div(32'd5, 32'd0, 1'b0, "div0");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "s_min_m1");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, "u_min_m1");
    do_div(32'hFFFFFFFF, 32'h80000001, 1'b0, "u_big_div");
    do_div(32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, "s_pos_neg");

    // Requests with annul set are not accepted
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    idle_quiet(3, "annul_in_free");
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    do_div(32'd9, 32'd3, 1'b0, "after_free_annul");

    // Annul mid-iteration (counter 10)
    begin_div(11);
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    check("annul_on_ready", 64'(ready_o), 64'd0);
    check("annul_on_result", result_o, 64'd0);
    annul_i = 1'b0;
    idle_quiet(40, "annul_on_quiet");
    do_div(32'd6, 32'd3, 1'b0, "u6_3");

    // Annul in BYZERO
    start_i   = 1'b1;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul_byzero_ready", 64'(ready_o), 64'd0);
    idle_quiet(5, "annul_byzero_quiet");

    // Reset mid-iteration (counter 20) with start still high
    begin_div(21);
    rst = 1'b1;
    tick();
    check("rst_on_ready", 64'(ready_o), 64'd0);
    check("rst_on_result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    idle_quiet(40, "rst_on_quiet");
    do_div(32'd1000, 32'd10, 1'b0, "after_rst");

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       a = 32'h80000000;
        default: b = b;
      endcase
      do_div(a, b, sgn, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
